// File: rtl/attack_status_unit_pkg.sv
// Shared constants for the attack status / hit-detection core.
package attack_status_unit_pkg;

    localparam int LARGURA   = 7;
    localparam int N_COLUNAS = 5;

    localparam logic LED_B_OFF = 1'b0;

endpackage

// File: rtl/attack_status_unit_if.sv
// Matrix comparison and status bundle between the map muxes, this core and the life counter.
interface attack_status_unit_if;
    import attack_status_unit_pkg::*;

    logic [LARGURA-1:0]   matriz0;
    logic [LARGURA-1:0]   matriz1;
    logic [LARGURA-1:0]   matriz2;
    logic [LARGURA-1:0]   matriz3;
    logic [LARGURA-1:0]   matriz4;
    logic [LARGURA-1:0]   proximo0;
    logic [LARGURA-1:0]   proximo1;
    logic [LARGURA-1:0]   proximo2;
    logic [LARGURA-1:0]   proximo3;
    logic [LARGURA-1:0]   proximo4;
    logic [N_COLUNAS-1:0] igual;
    logic                 errou_ataque;
    logic                 controle_vida;
    logic                 pulso_vida;
    logic                 LED_R;
    logic                 LED_G;
    logic                 LED_B;

    modport master (
        output matriz0, matriz1, matriz2, matriz3, matriz4,
        output proximo0, proximo1, proximo2, proximo3, proximo4,
        input  igual, errou_ataque, controle_vida, pulso_vida, LED_R, LED_G, LED_B
    );

    modport slave (
        input  matriz0, matriz1, matriz2, matriz3, matriz4,
        input  proximo0, proximo1, proximo2, proximo3, proximo4,
        output igual, errou_ataque, controle_vida, pulso_vida, LED_R, LED_G, LED_B
    );

endinterface

// File: rtl/attack_status_unit_cells.sv
// Leaf cells of the status core: column equality comparator, D flop and JK flop,
// both flops with asynchronous active-low reset.
module comparador_igualdade_7b
    import attack_status_unit_pkg::*;
(
    input  logic [LARGURA-1:0] i_a,
    input  logic [LARGURA-1:0] i_b,
    output logic               o_igual
);

    assign o_igual = (i_a == i_b);

endmodule

module ff_d_rst (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_q;

    // Capture D on the rising clock edge; reset clears immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= 1'b0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

module ff_jk_rst (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_j,
    input  logic i_k,
    output logic o_q
);

    logic r_q;

    // Classic JK update: set, clear, toggle or hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= 1'b0;
        end else begin
            case ({i_j, i_k})
                2'b10:   r_q <= 1'b1;
                2'b01:   r_q <= 1'b0;
                2'b11:   r_q <= ~r_q;
                default: r_q <= r_q;
            endcase
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/attack_status_unit.sv
// Hit/miss detection for a confirmed attack: a confirm that changes no matrix bit is a miss.
// Drives the life-counter strobe and the red/green status LEDs.
module attack_status_unit
    import attack_status_unit_pkg::*;
(
    input  logic                 confirmar,
    input  logic                 enable,
    attack_status_unit_if.slave  bus
);

    logic [LARGURA-1:0]   w_matriz  [N_COLUNAS];
    logic [LARGURA-1:0]   w_proximo [N_COLUNAS];
    logic [N_COLUNAS-1:0] w_igual;
    logic                 w_errou;
    logic                 w_controle_vida;
    logic                 w_j_r;
    logic                 w_j_g;
    logic                 w_led_r;
    logic                 w_led_g;

    assign w_matriz[0]  = bus.matriz0;
    assign w_matriz[1]  = bus.matriz1;
    assign w_matriz[2]  = bus.matriz2;
    assign w_matriz[3]  = bus.matriz3;
    assign w_matriz[4]  = bus.matriz4;
    assign w_proximo[0] = bus.proximo0;
    assign w_proximo[1] = bus.proximo1;
    assign w_proximo[2] = bus.proximo2;
    assign w_proximo[3] = bus.proximo3;
    assign w_proximo[4] = bus.proximo4;

    for (genvar gi = 0; gi < N_COLUNAS; gi++) begin : g_cmp
        comparador_igualdade_7b u_cmp (
            .i_a     (w_matriz[gi]),
            .i_b     (w_proximo[gi]),
            .o_igual (w_igual[gi])
        );
    end

    // Nothing changed anywhere: empty cell or a cell already hit.
    assign w_errou = &w_igual;

    ff_d_rst u_ff_vida (
        .i_clk   (confirmar),
        .i_rst_n (enable),
        .i_d     (w_errou),
        .o_q     (w_controle_vida)
    );

    // K is the complement of J, so each LED simply loads its J term on every confirm.
    assign w_j_r = w_errou & enable;
    assign w_j_g = ~w_errou & enable;

    ff_jk_rst u_ff_led_r (
        .i_clk   (confirmar),
        .i_rst_n (enable),
        .i_j     (w_j_r),
        .i_k     (~w_j_r),
        .o_q     (w_led_r)
    );

    ff_jk_rst u_ff_led_g (
        .i_clk   (confirmar),
        .i_rst_n (enable),
        .i_j     (w_j_g),
        .i_k     (~w_j_g),
        .o_q     (w_led_g)
    );

    assign bus.igual         = w_igual;
    assign bus.errou_ataque  = w_errou;
    assign bus.controle_vida = w_controle_vida;
    assign bus.pulso_vida    = w_controle_vida & confirmar;
    assign bus.LED_R         = w_led_r;
    assign bus.LED_G         = w_led_g;
    assign bus.LED_B         = LED_B_OFF;

endmodule

// File: tb/tb_attack_status_unit.sv
// Directed vector bench for attack_status_unit.
module tb_attack_status_unit;

    typedef struct {
        logic [4:0][6:0] mat;
        logic [4:0][6:0] prox;
        logic [4:0]      exp_igual;
        logic            exp_errou;
        logic            exp_ctrl;
        logic            exp_r;
        logic            exp_g;
    } vec_t;

    logic confirmar;
    logic enable;
    int   total;
    int   bad;
    vec_t vecs [6];

    attack_status_unit_if u_if ();

    attack_status_unit dut (
        .confirmar (confirmar),
        .enable    (enable),
        .bus       (u_if.master)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0][6:0] m, input logic [4:0][6:0] p);
        u_if.matriz0  = m[0];
        u_if.matriz1  = m[1];
        u_if.matriz2  = m[2];
        u_if.matriz3  = m[3];
        u_if.matriz4  = m[4];
        u_if.proximo0 = p[0];
        u_if.proximo1 = p[1];
        u_if.proximo2 = p[2];
        u_if.proximo3 = p[3];
        u_if.proximo4 = p[4];
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_ctrl"}, {7'd0, u_if.controle_vida}, 8'd0);
        check({tag, "_r"},    {7'd0, u_if.LED_R},         8'd0);
        check({tag, "_g"},    {7'd0, u_if.LED_G},         8'd0);
        check({tag, "_b"},    {7'd0, u_if.LED_B},         8'd0);
        check({tag, "_puls"}, {7'd0, u_if.pulso_vida},    8'd0);
    endtask

    initial begin
        logic [4:0][6:0] m;
        logic [4:0][6:0] p;
        total = 0;
        bad   = 0;

        // hit on column 0, column 1 holds an old hit
        m = '{default: 7'd0}; m[1] = 7'b0100000; p = m; p[0] = 7'b0000001;
        vecs[0] = '{m, p, 5'b11110, 1'b0, 1'b0, 1'b0, 1'b1};
        // miss on empty cell
        m = '{default: 7'd0}; m[1] = 7'b0100000; p = m;
        vecs[1] = '{m, p, 5'b11111, 1'b1, 1'b1, 1'b1, 1'b0};
        // repeated hit on same cell
        m = '{default: 7'd0}; m[0] = 7'b0000001; p = m;
        vecs[2] = '{m, p, 5'b11111, 1'b1, 1'b1, 1'b1, 1'b0};
        // hit on column 4, top row
        m = '{default: 7'd0}; p = m; p[4] = 7'b1000000;
        vecs[3] = '{m, p, 5'b01111, 1'b0, 1'b0, 1'b0, 1'b1};
        // differences in columns 2 and 3
        m = '{default: 7'b0010010}; p = m; p[2] = 7'b0011010; p[3] = 7'b1010010;
        vecs[4] = '{m, p, 5'b10011, 1'b0, 1'b0, 1'b0, 1'b1};
        // fully hit matrix, nothing can change
        m = '{default: 7'h7F}; p = m;
        vecs[5] = '{m, p, 5'b11111, 1'b1, 1'b1, 1'b1, 1'b0};

        confirmar = 1'b0;
        enable    = 1'b0;
        drive(vecs[1].mat, vecs[1].prox);
        #5;

        // reset held: confirm edges must not move anything
        for (int i = 0; i < 3; i++) begin
            confirmar = 1'b1; #1;
            check_cleared("rst_hi");
            #4; confirmar = 1'b0; #1;
            check_cleared("rst_lo");
            #4;
        end

        enable = 1'b1;
        #5;
        check_cleared("en_up");

        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].mat, vecs[i].prox);
            #1;
            check($sformatf("v%0d_igual", i), {3'd0, u_if.igual}, {3'd0, vecs[i].exp_igual});
            check($sformatf("v%0d_errou", i), {7'd0, u_if.errou_ataque}, {7'd0, vecs[i].exp_errou});
            #4;
            confirmar = 1'b1; #1;
            check($sformatf("v%0d_ctrl", i), {7'd0, u_if.controle_vida}, {7'd0, vecs[i].exp_ctrl});
            check($sformatf("v%0d_r", i),    {7'd0, u_if.LED_R},         {7'd0, vecs[i].exp_r});
            check($sformatf("v%0d_g", i),    {7'd0, u_if.LED_G},         {7'd0, vecs[i].exp_g});
            check($sformatf("v%0d_b", i),    {7'd0, u_if.LED_B},         8'd0);
            check($sformatf("v%0d_puls_hi", i), {7'd0, u_if.pulso_vida}, {7'd0, vecs[i].exp_ctrl});
            #4; confirmar = 1'b0; #1;
            check($sformatf("v%0d_puls_lo", i), {7'd0, u_if.pulso_vida}, 8'd0);
            check($sformatf("v%0d_hold", i), {6'd0, u_if.LED_R, u_if.controle_vida},
                  {6'd0, vecs[i].exp_r, vecs[i].exp_ctrl});
            #4;
        end

        // reset mid-operation while confirm is high, after a miss
        drive(vecs[5].mat, vecs[5].prox);
        confirmar = 1'b1; #1;
        check("mid_pre_r", {7'd0, u_if.LED_R}, 8'd1);
        enable = 1'b0; #1;
        check_cleared("mid_rst");
        enable = 1'b1; #1;
        check_cleared("mid_en_hi");
        #3; confirmar = 1'b0; #1;
        check_cleared("mid_en_lo");
        drive(vecs[0].mat, vecs[0].prox);
        #4; confirmar = 1'b1; #1;
        check("mid_next_g",    {7'd0, u_if.LED_G},         8'd1);
        check("mid_next_r",    {7'd0, u_if.LED_R},         8'd0);
        check("mid_next_ctrl", {7'd0, u_if.controle_vida}, 8'd0);
        #4; confirmar = 1'b0; #5;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
